// File: rtl/lcd_cmd_host.sv
// lcd_cmd_host: queues 4-bit commands for the 8x8 LCD controller, issues them against busy,
// and captures the 64-byte IRAM write stream. Define CMD_TIMEOUT_EN to add the watchdog.
module lcd_cmd_host #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd_in,
  input  logic        cmd_in_valid,
  output logic        cmd_in_ready,
  input  logic        start,
  input  logic        busy,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        IRAM_valid,
  input  logic [5:0]  IRAM_A,
  input  logic [7:0]  IRAM_D,
  input  logic        done,
  output logic [13:0] img_sum,
  output logic [6:0]  wr_count,
  output logic        finished,
  output logic        err,
  output logic        timeout
);

  // state      | meaning
  // IDLE       | accepting script pushes, waiting for start
  // WAIT_READY | waiting for busy=0 with a queued command
  // ISSUE      | cmd_valid strobe, FIFO head popped
  // GUARD      | one cycle ignoring busy while the controller updates
  // WAIT_BUSY  | waiting for the controller to drop busy
  // CAPTURE    | accumulating IRAM write beats
  // FINISH     | sequence complete, held until reset
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_READY = 3'd1;
  localparam logic [2:0] S_ISSUE      = 3'd2;
  localparam logic [2:0] S_GUARD      = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY  = 3'd4;
  localparam logic [2:0] S_CAPTURE    = 3'd5;
  localparam logic [2:0] S_FINISH     = 3'd6;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [2:0]    state, state_nx, state_d;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          fifo_empty, fifo_full, push, pop;
  logic          beat, cap_end, wd_fire, err_set;
  logic [6:0]    wr_count_nx;

  assign fifo_empty   = (occ == '0);
  assign fifo_full    = (occ == FULL_OCC);
  assign pop          = (state == S_ISSUE);
  // A slot freed by this cycle's pop may be refilled in the same cycle.
  assign cmd_in_ready = (!fifo_full || pop) && (state != S_FINISH);
  assign push         = cmd_in_valid && cmd_in_ready;
  assign cmd_valid    = (state == S_ISSUE);
  assign finished     = (state == S_FINISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cmd_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign beat        = (state == S_CAPTURE) && IRAM_valid;
  assign wr_count_nx = wr_count + {6'd0, beat};
  assign cap_end     = (wr_count_nx == 7'd64) || done;
  assign err_set     = (IRAM_valid && (state != S_CAPTURE))
                    || (beat && (IRAM_A != wr_count[5:0]))
                    || ((state == S_CAPTURE) && done && (wr_count_nx < 7'd64))
                    || wd_fire;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (start) state_nx = S_WAIT_READY;
      S_WAIT_READY: if (!busy && !fifo_empty) state_nx = S_ISSUE;
      S_ISSUE:      state_nx = (cmd == 4'd0) ? S_CAPTURE : S_GUARD;
      S_GUARD:      state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY:  if (!busy) state_nx = S_WAIT_READY;
      S_CAPTURE:    if (cap_end) state_nx = S_FINISH;
      S_FINISH:     state_nx = S_FINISH;
      default:      state_nx = S_IDLE;
    endcase
  end

  assign state_d = wd_fire ? S_FINISH : state_nx;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] wd_cnt;
  logic          wd_timed, wd_reload, timeout_q;

  assign wd_timed  = (state == S_GUARD) || (state == S_WAIT_BUSY) || (state == S_CAPTURE);
  assign wd_reload = (state_nx != state) || beat;
  assign wd_fire   = wd_timed && !wd_reload && (wd_cnt == '0);
  assign timeout   = timeout_q;

  // Down-counter preloaded with TIMEOUT-1; terminal count marks the TIMEOUT-th idle cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= WD_LOAD;
      timeout_q <= 1'b0;
    end else begin
      if (wd_reload || !wd_timed) wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0)      wd_cnt <= wd_cnt - 1'b1;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cmd      <= 4'd0;
      img_sum  <= 14'd0;
      wr_count <= 7'd0;
      err      <= 1'b0;
    end else begin
      state <= state_d;
      if (state_d == S_ISSUE) cmd <= mem[rd_ptr];
      if (beat) img_sum <= img_sum + {6'd0, IRAM_D};
      wr_count <= wr_count_nx;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: doc/lcd_cmd_host.md
Name: lcd_cmd_host

Overview:
Host-side command sequencer and image sink for the 8x8 LCD controller. It queues a script of 4-bit commands and issues them one at a time on the controller's cmd/cmd_valid interface, honouring busy. After the write command (cmd 0) it captures the controller's 64-byte IRAM write stream, accumulating a byte sum and checking that addresses arrive in order. It is the bench/system-side counterpart that drives the controller and consumes its IRAM output.

Parameters:
DEPTH, 16, command FIFO depth (power of 2, >=2)
TIMEOUT, 255, watchdog limit in cycles (used only with CMD_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset)
cmd_in  input  4  command to enqueue
cmd_in_valid  input  1  enqueue request
cmd_in_ready  output  1  FIFO not full and not FINISH
start  input  1  one-cycle pulse that arms issuing
busy  input  1  controller busy
cmd  output  4  command to controller
cmd_valid  output  1  one-cycle command strobe
IRAM_valid  input  1  controller write strobe
IRAM_A  input  6  controller write address
IRAM_D  input  8  controller write data
done  input  1  controller completion
img_sum  output  14  sum of captured bytes
wr_count  output  7  captured beats, 0..64
finished  output  1  sequence complete, sticky
err  output  1  sticky protocol error
timeout  output  1  watchdog expiry, sticky (0 without CMD_TIMEOUT_EN)

Behaviour:
- Reset (reset=0, async): FIFO empty, state IDLE, cmd=0, cmd_valid=0, img_sum=0, wr_count=0, finished=0, err=0, timeout=0.
- FIFO: push when cmd_in_valid && cmd_in_ready; pop only on issue. Push and pop in the same cycle are legal; occupancy is unchanged. Push while not ready is dropped. Pointers wrap modulo DEPTH.
- States: IDLE, WAIT_READY, ISSUE, GUARD, WAIT_BUSY, CAPTURE, FINISH.
- IDLE: start=1 -> WAIT_READY. Pushes are accepted.
- WAIT_READY: busy=0 && FIFO non-empty -> ISSUE. An empty FIFO holds the state indefinitely.
- ISSUE (exactly 1 cycle): cmd_valid=1, cmd=FIFO head, pop. If head==0 -> CAPTURE, otherwise -> GUARD. cmd is registered and holds its last value outside ISSUE.
- GUARD (1 cycle): ignores busy, which covers the controller's half-cycle state update. -> WAIT_BUSY.
- WAIT_BUSY: busy=0 -> WAIT_READY.
- CAPTURE: on each IRAM_valid=1 cycle, img_sum += IRAM_D and wr_count += 1. If IRAM_A != wr_count[5:0], set err.
  - wr_count reaching 64, or done=1, -> FINISH.
  - A beat on the same cycle as done is counted.
  - done with wr_count<64 sets err.
- FINISH: finished=1, cmd_in_ready=0, start ignored. The state is held until reset.
- IRAM_valid outside CAPTURE is ignored and sets err.
- cmd_valid is never asserted while busy=1 is sampled in WAIT_READY.
- img_sum max is 64*255=16320, so it never overflows 14 bits.
- Reset asserted mid-operation returns everything to reset values immediately, including the FIFO contents.

Optional Feature:
CMD_TIMEOUT_EN
- Defined: a cycle counter runs in GUARD/WAIT_BUSY/CAPTURE and clears on every state change and every IRAM_valid beat. Reaching TIMEOUT sets timeout=1 and err=1 and enters FINISH.
- Undefined: no counter; those states wait indefinitely; timeout is tied to 0.

Test Plan:
- Push 1,1,0; start; busy=1 for 64 cycles -> no cmd_valid until busy=0, then cmd=1 issued as a single-cycle pulse.
- Same script; controller model holds busy 3 cycles per command -> cmd_valid pulses issue in order 1,1,0, each only after busy falls; FIFO ends empty.
- After cmd 0: 64 beats with IRAM_A=0..63, IRAM_D=A+1 -> img_sum=2080, wr_count=64, finished=1, err=0.
- Beats with IRAM_A sequence 0,1,3 -> err=1 at third beat; capture continues; done at beat 10 -> finished=1, wr_count=10.
- Push 16 entries with DEPTH=16 -> cmd_in_ready=0 and 17th push dropped; push+issue in same cycle -> occupancy stays 16.
- CMD_TIMEOUT_EN, TIMEOUT=20: busy stuck 1 after issue -> timeout=1, err=1, finished=1 at cycle 21 after GUARD. Separately, reset pulsed low mid-CAPTURE -> all outputs return to 0.
